// File: rtl/modular_mul_barrett.sv
// -----------------------------------------------------------------------------
// modular_mul_barrett
//   Pipelined modular multiplier z = (x * y) mod M using Barrett reduction,
//   M = 12289. Feeds the twiddle product w*b to the NTT butterfly adder.
//   One operand pair per enabled cycle, fixed latency of 4 enabled edges.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset (clears data and valid)
//   en         in   pipeline advance; 0 freezes every stage
//   in_valid   in   x_mul / y_mul hold a valid pair
//   x_mul      in   operand, expected < M
//   y_mul      in   operand, expected < M
//   out_valid  out  z_mul is valid this cycle
//   z_mul      out  (x_mul * y_mul) mod M, fully reduced to [0, M-1]
//
// Stages
//   S1  p  = x * y
//   S2  qh = (p * BARRETT_M) >> K      (p carried alongside)
//   S3  r  = p - qh * M                (r < 3M, fits DATA_WIDTH+2 bits)
//   S4  z  = r reduced by up to two subtractions of M
// -----------------------------------------------------------------------------
module modular_mul_barrett #(
  parameter int unsigned DATA_WIDTH = 14,
  parameter int unsigned M          = 12289,
  parameter int unsigned K          = 2 * DATA_WIDTH,
  parameter int unsigned BARRETT_M  = 21843
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] x_mul,
  input  logic [DATA_WIDTH-1:0] y_mul,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] z_mul
);

  localparam int unsigned PW = 2 * DATA_WIDTH;  // full product width
  localparam int unsigned BW = 15;              // width of BARRETT_M
  localparam int unsigned XW = PW + BW;         // p * BARRETT_M before shift
  localparam int unsigned QW = DATA_WIDTH + 1;  // quotient estimate width
  localparam int unsigned RW = DATA_WIDTH + 2;  // partial remainder width

  // Stage registers and their next-state values
  logic [PW-1:0]         p_q,  p_d;
  logic                  v1_q;
  logic [PW-1:0]         p2_q;
  logic [QW-1:0]         qh_q, qh_d;
  logic                  v2_q;
  logic [RW-1:0]         r_q,  r_d;
  logic                  v3_q;
  logic [DATA_WIDTH-1:0] z_q,  z_d;
  logic                  v4_q;

  // Combinational intermediates
  logic [XW-1:0] pm_full;
  logic [RW-1:0] qm;
  logic [RW-1:0] r1;
  logic [RW-1:0] r2;

  // NOTE: every signal assigned in always_comb gets an unconditional value
  // first; a path that leaves one unassigned would infer a latch.
  always_comb begin
    p_d     = '0;
    pm_full = '0;
    qh_d    = '0;
    qm      = '0;
    r_d     = '0;
    r1      = '0;
    r2      = '0;
    z_d     = '0;

    // S1: full-width product
    p_d = PW'(x_mul) * PW'(y_mul);

    // S2: the whole (PW+15)-bit product is formed before shifting so no
    // quotient bits are lost; the estimate undershoots the true quotient by
    // at most 2, which is what the two corrections in S4 absorb.
    pm_full = XW'(p_q) * XW'(BARRETT_M);
    qh_d    = QW'(pm_full >> K);

    // S3: true remainder is < 3M < 2^RW, so computing modulo 2^RW is exact.
    qm  = RW'(qh_q) * RW'(M);
    r_d = RW'(p2_q) - qm;

    // S4: two conditional subtractions bring r from [0, 3M) into [0, M).
    r1  = (r_q >= RW'(M)) ? (r_q - RW'(M)) : r_q;
    r2  = (r1  >= RW'(M)) ? (r1  - RW'(M)) : r1;
    z_d = DATA_WIDTH'(r2);
  end

  // NOTE: state registers use non-blocking assignments so every stage samples
  // the previous stage's value from before this edge; blocking assignments
  // would let data race through several stages in a single cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q  <= '0;
      v1_q <= 1'b0;
      p2_q <= '0;
      qh_q <= '0;
      v2_q <= 1'b0;
      r_q  <= '0;
      v3_q <= 1'b0;
      z_q  <= '0;
      v4_q <= 1'b0;
    end else if (en) begin
      // Valid bits travel with their data; a bubble (in_valid=0) propagates
      // as valid=0 while its data fields are don't-care.
      p_q  <= p_d;
      v1_q <= in_valid;
      p2_q <= p_q;
      qh_q <= qh_d;
      v2_q <= v1_q;
      r_q  <= r_d;
      v3_q <= v2_q;
      z_q  <= z_d;
      v4_q <= v3_q;
    end
  end

  assign out_valid = v4_q;
  assign z_mul     = z_q;

endmodule
